sig_window_stats: RTL and testbench

SIG_WINDOW_STATS -- requirements
Module: sig_window_stats

---
 rtl/sig_window_stats.sv | 140 ++++++++++++++
 tb/tb_sig_window_stats.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/sig_window_stats.sv
// rtl/sig_window_stats.sv - windowed max/min/peak-to-peak and hysteretic zero-crossing statistics
//
// Purpose: collects 2^WIN_LG accepted samples per window and publishes the
// window's max, min, peak-to-peak span and rising zero-crossing count.
//
// Ports:
//   clk         - clock, all state updates on rising edge
//   rst         - asynchronous active-high reset
//   en          - measurement enable (IDLE->ACQ when high, ACQ->IDLE when low)
//   s_valid     - qualifies s_in
//   s_in        - signed sample, DATA_W bits
//   max_out     - maximum of last completed window
//   min_out     - minimum of last completed window
//   p2p_out     - max_out - min_out, DATA_W+1 bits unsigned
//   zc_count    - rising hysteretic zero crossings in last completed window
//   stats_valid - one-cycle pulse when the stat outputs update
//   busy        - high while acquiring
module sig_window_stats #(
  parameter int DATA_W = 19,
  parameter int WIN_LG = 10,
  parameter int HYST   = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     s_valid,
  input  logic signed [DATA_W-1:0] s_in,
  output logic signed [DATA_W-1:0] max_out,
  output logic signed [DATA_W-1:0] min_out,
  output logic        [DATA_W:0]   p2p_out,
  output logic        [WIN_LG-1:0] zc_count,
  output logic                     stats_valid,
  output logic                     busy
);

  typedef enum logic {ST_IDLE, ST_ACQ} state_t;
  typedef enum logic [1:0] {POL_UNK, POL_NEG, POL_POS} pol_t;

  localparam logic signed [DATA_W-1:0] LP_HYST_P = DATA_W'(HYST);
  localparam logic signed [DATA_W-1:0] LP_HYST_N = -LP_HYST_P;
  localparam logic        [WIN_LG-1:0] LP_ZC_MAX = '1;
  localparam logic        [WIN_LG-1:0] LP_CNT_LAST = '1;

  state_t                     r_state;
  pol_t                       r_pol;
  logic        [WIN_LG-1:0]   r_cnt;
  logic signed [DATA_W-1:0]   r_max;
  logic signed [DATA_W-1:0]   r_min;
  logic        [WIN_LG-1:0]   r_zc;

  logic                       w_first;
  logic                       w_last;
  logic                       w_neg;
  logic                       w_pos;
  logic                       w_cross;
  logic signed [DATA_W-1:0]   w_max_nxt;
  logic signed [DATA_W-1:0]   w_min_nxt;
  logic        [WIN_LG-1:0]   w_zc_base;
  logic        [WIN_LG-1:0]   w_zc_nxt;
  logic        [DATA_W:0]     w_p2p;

  assign w_first = (r_cnt == '0);
  assign w_last  = (r_cnt == LP_CNT_LAST);

  // The first sample of a window seeds the extremes instead of comparing
  // against the previous window's leftovers.
  assign w_max_nxt = (w_first || (s_in > r_max)) ? s_in : r_max;
  assign w_min_nxt = (w_first || (s_in < r_min)) ? s_in : r_min;

  // Negative threshold takes priority so HYST=0 never counts on a zero sample.
  assign w_neg   = (s_in <= LP_HYST_N);
  assign w_pos   = (s_in >= LP_HYST_P) && !w_neg;
  assign w_cross = w_pos && (r_pol == POL_NEG);

  assign w_zc_base = w_first ? '0 : r_zc;
  assign w_zc_nxt  = (w_cross && (w_zc_base != LP_ZC_MAX)) ? w_zc_base + WIN_LG'(1) : w_zc_base;

  // Sign-extend both operands by one bit so full-scale spans cannot wrap.
  assign w_p2p = {w_max_nxt[DATA_W-1], w_max_nxt} - {w_min_nxt[DATA_W-1], w_min_nxt};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_pol       <= POL_UNK;
      r_cnt       <= '0;
      r_max       <= '0;
      r_min       <= '0;
      r_zc        <= '0;
      max_out     <= '0;
      min_out     <= '0;
      p2p_out     <= '0;
      zc_count    <= '0;
      stats_valid <= 1'b0;
      busy        <= 1'b0;
    end else begin
      stats_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_pol <= POL_UNK;
          r_cnt <= '0;
          if (en) begin
            r_state <= ST_ACQ;
            busy    <= 1'b1;
          end
        end
        ST_ACQ: begin
          if (!en) begin
            // Abandon the partial window; published stats are left untouched.
            r_state <= ST_IDLE;
            busy    <= 1'b0;
            r_pol   <= POL_UNK;
            r_cnt   <= '0;
            r_max   <= '0;
            r_min   <= '0;
            r_zc    <= '0;
          end else if (s_valid) begin
            r_cnt <= r_cnt + WIN_LG'(1);
            r_max <= w_max_nxt;
            r_min <= w_min_nxt;
            r_zc  <= w_zc_nxt;
            if (w_neg) begin
              r_pol <= POL_NEG;
            end else if (w_pos) begin
              r_pol <= POL_POS;
            end
            if (w_last) begin
              max_out     <= w_max_nxt;
              min_out     <= w_min_nxt;
              p2p_out     <= w_p2p;
              zc_count    <= w_zc_nxt;
              stats_valid <= 1'b1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sig_window_stats.sv
// tb/tb_sig_window_stats.sv - self-checking bench for sig_window_stats
module tb_sig_window_stats;

  localparam int DW   = 19;
  localparam int WL   = 3;
  localparam int HY   = 2;
  localparam int WLEN = 8;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 en;
  logic                 s_valid;
  logic signed [DW-1:0] s_in;
  logic signed [DW-1:0] max_out;
  logic signed [DW-1:0] min_out;
  logic        [DW:0]   p2p_out;
  logic        [WL-1:0] zc_count;
  logic                 stats_valid;
  logic                 busy;

  int n_pass = 0;
  int n_total = 0;

  sig_window_stats #(.DATA_W(DW), .WIN_LG(WL), .HYST(HY)) dut (
    .clk(clk), .rst(rst), .en(en), .s_valid(s_valid), .s_in(s_in),
    .max_out(max_out), .min_out(min_out), .p2p_out(p2p_out),
    .zc_count(zc_count), .stats_valid(stats_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference model: queue of samples in the current window, polarity as
  // 0=unknown 1=neg 2=pos, published results held in plain integers.
  int m_acq;
  int m_pol;
  int m_cross;
  int m_win[$];
  int m_max, m_min, m_p2p, m_zc, m_sv;

  function automatic void model_reset();
    m_acq = 0; m_pol = 0; m_cross = 0; m_win.delete();
    m_max = 0; m_min = 0; m_p2p = 0; m_zc = 0; m_sv = 0;
  endfunction

  function automatic void model_step(input bit e, input bit v, input int x);
    int mx, mn;
    m_sv = 0;
    if (m_acq == 0) begin
      m_pol = 0;
      if (e) m_acq = 1;
    end else if (!e) begin
      m_acq = 0; m_pol = 0; m_cross = 0; m_win.delete();
    end else if (v) begin
      if (x <= -HY) m_pol = 1;
      else if (x >= HY) begin
        if (m_pol == 1) m_cross++;
        m_pol = 2;
      end
      m_win.push_back(x);
      if (m_win.size() == WLEN) begin
        mx = m_win[0]; mn = m_win[0];
        foreach (m_win[k]) begin
          if (m_win[k] > mx) mx = m_win[k];
          if (m_win[k] < mn) mn = m_win[k];
        end
        m_max = mx; m_min = mn; m_p2p = mx - mn;
        m_zc = (m_cross > WLEN - 1) ? WLEN - 1 : m_cross;
        m_sv = 1;
        m_win.delete();
        m_cross = 0;
      end
    end
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic drive(input bit e, input bit v, input int x);
    @(negedge clk);
    en = e; s_valid = v; s_in = x[DW-1:0];
    model_step(e, v, x);
    @(posedge clk);
    #1;
  endtask

  task automatic cmp_model(input string tag);
    chk({tag, "_sv"},   stats_valid, m_sv);
    chk({tag, "_busy"}, busy,        m_acq);
    chk({tag, "_max"},  max_out,     m_max);
    chk({tag, "_min"},  min_out,     m_min);
    chk({tag, "_p2p"},  p2p_out,     m_p2p);
    chk({tag, "_zc"},   zc_count,    m_zc);
  endtask

  task automatic chk_stats(input string tag, input int mx, input int mn, input int pp, input int zc);
    chk({tag, "_max"}, max_out,  mx);
    chk({tag, "_min"}, min_out,  mn);
    chk({tag, "_p2p"}, p2p_out,  pp);
    chk({tag, "_zc"},  zc_count, zc);
  endtask

  typedef struct {
    bit e; bit v; int x;
    bit sv; int mx; int mn; int pp; int zc; bit bz;
  } vec_t;

  vec_t tbl[18];

  initial begin
    int acc;
    int pulses;
    int pos_q[$];

    // Ramp window then full-scale alternating window, back to back.
    tbl[0] = '{1'b1, 1'b0, 0, 1'b0, 0, 0, 0, 0, 1'b1};
    for (int i = 1; i <= 8; i++) begin
      if (i == 8) tbl[i] = '{1'b1, 1'b1, i - 5, 1'b1, 3, -4, 7, 1, 1'b1};
      else        tbl[i] = '{1'b1, 1'b1, i - 5, 1'b0, 0, 0, 0, 0, 1'b1};
    end
    tbl[9] = '{1'b1, 1'b0, 0, 1'b0, 3, -4, 7, 1, 1'b1};
    for (int i = 10; i <= 17; i++) begin
      int fx;
      fx = ((i - 10) % 2 == 0) ? -262144 : 262143;
      if (i == 17) tbl[i] = '{1'b1, 1'b1, fx, 1'b1, 262143, -262144, 524287, 4, 1'b1};
      else         tbl[i] = '{1'b1, 1'b1, fx, 1'b0, 3, -4, 7, 1, 1'b1};
    end

    rst = 1'b1; en = 1'b0; s_valid = 1'b0; s_in = '0;
    model_reset();
    #2;
    chk_stats("reset", 0, 0, 0, 0);
    chk("reset_sv", stats_valid, 0);
    chk("reset_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 1'b0, 0);
    cmp_model("idle");

    for (int i = 0; i < 18; i++) begin
      drive(tbl[i].e, tbl[i].v, tbl[i].x);
      chk($sformatf("tbl%0d_sv", i),   stats_valid, tbl[i].sv);
      chk($sformatf("tbl%0d_busy", i), busy,        tbl[i].bz);
      chk($sformatf("tbl%0d_max", i),  max_out,     tbl[i].mx);
      chk($sformatf("tbl%0d_min", i),  min_out,     tbl[i].mn);
      chk($sformatf("tbl%0d_p2p", i),  p2p_out,     tbl[i].pp);
      chk($sformatf("tbl%0d_zc", i),   zc_count,    tbl[i].zc);
    end

    // Asynchronous reset in the middle of a window, between clock edges.
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 7 + i);
    #2;
    rst = 1'b1;
    #1;
    chk_stats("arst", 0, 0, 0, 0);
    chk("arst_sv", stats_valid, 0);
    chk("arst_busy", busy, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, 1'b0, 0);
    cmp_model("arst_en");
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b1, i - 4);
      chk($sformatf("arst_ramp%0d_sv", i), stats_valid, (i == 7));
    end
    chk_stats("arst_ramp", 3, -4, 7, 1);

    // Same ramp with s_valid gaps across 20 cycles.
    acc = 0;
    for (int i = 0; i < 20; i++) begin
      bit v;
      v = (i % 5 == 1) || (i % 5 == 3);
      drive(1'b1, v, v ? acc - 4 : 99);
      chk($sformatf("gap%0d_sv", i), stats_valid, v && (acc == 7));
      cmp_model($sformatf("gap%0d", i));
      if (v) acc++;
    end
    chk("gap_accepted", acc, 8);
    chk_stats("gap", 3, -4, 7, 1);

    // Abort after 5 samples: no pulse, outputs hold, fresh window afterwards.
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b1, 10 + i);
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b0, 0);
      chk($sformatf("abort%0d_sv", i), stats_valid, 0);
      chk($sformatf("abort%0d_busy", i), busy, 0);
      chk_stats($sformatf("abort%0d", i), 3, -4, 7, 1);
    end
    drive(1'b1, 1'b0, 0);
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b1, (i % 2 == 0) ? 5 : -5);
      chk($sformatf("reen%0d_sv", i), stats_valid, (i == 7));
    end
    chk_stats("reen", 5, -5, 10, 3);

    // 24 back-to-back samples: pulses at sample indices 7, 15, 23.
    pulses = 0;
    for (int i = 0; i < 24; i++) begin
      drive(1'b1, 1'b1, int'($urandom_range(0, 12)) - 6);
      cmp_model($sformatf("b2b%0d", i));
      if (stats_valid) begin
        pulses++;
        pos_q.push_back(i);
      end
    end
    chk("b2b_pulses", pulses, 3);
    for (int k = 0; k < pos_q.size() && k < 3; k++)
      chk($sformatf("b2b_pos%0d", k), pos_q[k], 7 + 8 * k);

    // Randomised traffic against the model.
    for (int i = 0; i < 600; i++) begin
      bit e, v;
      int x;
      logic signed [DW-1:0] r19;
      e = ($urandom_range(0, 39) != 0);
      v = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 3) == 0) begin
        r19 = DW'($urandom);
        x = r19;
      end else begin
        x = int'($urandom_range(0, 10)) - 5;
      end
      drive(e, v, x);
      cmp_model($sformatf("rnd%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
